// File: rtl/lsu_pkg.sv
// lsu_pkg: size encodings, FSM state type and lane helpers shared by the
// load/store unit and its lane alignment logic.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    RESP = 2'b11
  } lsu_state_t;

  localparam logic [31:0] BYTE_MASK = 32'h0000_00ff;
  localparam logic [31:0] HALF_MASK = 32'h0000_ffff;

  // Bit offset of the addressed lane; halfwords only look at addr[1].
  function automatic logic [4:0] lane_shift(input logic [1:0] size, input logic [1:0] lane);
    lane_shift = (size == SZ_HALF) ? {lane[1], 4'b0000} : {lane, 3'b000};
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: little-endian lane extraction for sub-word loads (with
// sign/zero extension) and lane merge for read-modify-write stores.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        is_unsigned,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged_data
);

  logic [4:0]  shift;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign shift    = lane_shift(size, lane);
  assign byte_sel = rdata[{lane, 3'b000} +: 8];
  assign half_sel = lane[1] ? rdata[31:16] : rdata[15:0];

  // Pick the addressed lane for loads and splice the new lane into the old word for stores.
  always_comb begin
    load_data   = rdata;
    merged_data = wdata;
    case (size)
      SZ_BYTE: begin
        load_data   = is_unsigned ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
        merged_data = (rdata & ~(BYTE_MASK << shift)) | ((wdata & BYTE_MASK) << shift);
      end
      SZ_HALF: begin
        load_data   = is_unsigned ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
        merged_data = (rdata & ~(HALF_MASK << shift)) | ((wdata & HALF_MASK) << shift);
      end
      default: begin
        load_data   = rdata;
        merged_data = wdata;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: drives the word-addressed data memory for one load/store
// request at a time and returns a one-cycle response.
// Define LSU_SUBWORD_EN to enable byte/halfword accesses (including
// read-modify-write stores); without it only word accesses are legal.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 256
)
(
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [31:0] ADDR_LIMIT = 32'(MEM_WORDS * 4);

  lsu_state_t state;
  logic       req_error;

`ifdef LSU_SUBWORD_EN
  logic        r_write;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [1:0]  r_lane;
  logic [31:0] r_wdata;
  logic [31:0] load_data;
  logic [31:0] merged_data;

  lsu_lane_align u_align (
    .size        (r_size),
    .lane        (r_lane),
    .is_unsigned (r_unsigned),
    .rdata       (mem_rdata),
    .wdata       (r_wdata),
    .load_data   (load_data),
    .merged_data (merged_data)
  );
`else
  logic unused_req_unsigned;
  assign unused_req_unsigned = req_unsigned;
`endif

  assign req_ready = (state == IDLE) & ~reset;
  assign mem_read  = (state == RD) & ~reset;
  assign mem_write = (state == WR) & ~reset;

  // Reject reserved sizes, misaligned accesses and addresses past the end of memory.
  always_comb begin
    req_error = (req_addr >= ADDR_LIMIT);
`ifdef LSU_SUBWORD_EN
    if (req_size == SZ_HALF && req_addr[0])
      req_error = 1'b1;
    else if (req_size == SZ_WORD && req_addr[1:0] != 2'b00)
      req_error = 1'b1;
    else if (req_size != SZ_BYTE && req_size != SZ_HALF && req_size != SZ_WORD)
      req_error = 1'b1;
`else
    if (req_size != SZ_WORD || req_addr[1:0] != 2'b00)
      req_error = 1'b1;
`endif
  end

  // Request FSM: capture on accept, access memory, then pulse the response.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
      mem_addr   <= 32'h0;
      mem_wdata  <= 32'h0;
`ifdef LSU_SUBWORD_EN
      r_write    <= 1'b0;
      r_size     <= SZ_WORD;
      r_unsigned <= 1'b0;
      r_lane     <= 2'b00;
      r_wdata    <= 32'h0;
`endif
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            mem_addr  <= {req_addr[31:2], 2'b00};
            mem_wdata <= req_wdata;
`ifdef LSU_SUBWORD_EN
            r_write    <= req_write;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_lane     <= req_addr[1:0];
            r_wdata    <= req_wdata;
`endif
            if (req_error) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'h0;
              state      <= RESP;
            end else if (req_write && req_size == SZ_WORD) begin
              state <= WR;
            end else begin
              state <= RD;
            end
          end
        end
        RD: begin
`ifdef LSU_SUBWORD_EN
          if (r_write) begin
            mem_wdata <= merged_data;
            state     <= WR;
          end else begin
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= load_data;
            state      <= RESP;
          end
`else
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= mem_rdata;
          state      <= RESP;
`endif
        end
        WR: begin
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= 32'h0;
          state      <= RESP;
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed requests against a behavioural word memory.
// Stimulus pushes the expected response into a scoreboard queue; a monitor
// pops and compares whenever resp_valid is seen.
module tb_load_store_unit;

  localparam int         MEM_WORDS = 256;
  localparam logic [1:0] B  = 2'b00;
  localparam logic [1:0] H  = 2'b01;
  localparam logic [1:0] W  = 2'b10;
  localparam logic [1:0] RS = 2'b11;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  typedef struct {
    string       name;
    int          due;
    logic [31:0] rdata;
    logic        err;
    int          reads;
    int          writes;
    int          rd_base;
    int          wr_base;
    int          ov_base;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          rd_count = 0;
  int          wr_count = 0;
  int          ov_count = 0;
  int          passed = 0;
  int          total = 0;
  logic        tb_init;
  logic [31:0] mem [0:MEM_WORDS-1];

  load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  always #5 clock = ~clock;

  // Cycle counter: value k during cycle k.
  always @(posedge clock) cyc <= cyc + 1;

  // Word memory: preloaded while tb_init is high, written at the edge ending a mem_write cycle.
  always @(posedge clock) begin
    if (tb_init) begin
      for (int i = 0; i < MEM_WORDS; i++) mem[i] <= 32'h0;
      mem[0]           <= 32'h0000_0005;
      mem[MEM_WORDS-1] <= 32'hCAFE_F00D;
    end else if (mem_write) begin
      mem[mem_addr[9:2]] <= mem_wdata;
    end
  end

  assign mem_rdata = mem_read ? mem[mem_addr[9:2]] : 32'hBAD0_BAD0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
  endtask

  task automatic stepCycle();
    @(negedge clock);
    #1;
  endtask

  // Monitor: count memory strobes and check every response against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (mem_read) rd_count++;
      if (mem_write) wr_count++;
      if (mem_read && mem_write) ov_count++;
      if (resp_valid) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_resp", 32'(resp_valid), 32'h0);
        end else begin
          e = sb.pop_front();
          checkOutput({e.name, "_rdata"}, resp_rdata, e.rdata);
          checkOutput({e.name, "_err"}, 32'(resp_err), 32'(e.err));
          checkOutput({e.name, "_cycle"}, 32'(cyc), 32'(e.due));
          checkOutput({e.name, "_reads"}, 32'(rd_count - e.rd_base), 32'(e.reads));
          checkOutput({e.name, "_writes"}, 32'(wr_count - e.wr_base), 32'(e.writes));
          checkOutput({e.name, "_overlap"}, 32'(ov_count - e.ov_base), 32'h0);
        end
      end
    end
  end

  task automatic waitReady(input string name);
    int waited = 0;
    while (!req_ready && waited < 10) begin
      stepCycle();
      waited++;
    end
    if (!req_ready) checkOutput({name, "_ready_timeout"}, 32'(req_ready), 32'h1);
  endtask

  // Issue one request, record its expected response, and wait for it to drain.
  task automatic applyStimulus(input string name, input logic wr, input logic [1:0] sz,
                               input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] exp_rdata, input logic exp_err,
                               input int lat, input int nrd, input int nwr);
    exp_t e;
    int   waited = 0;
    waitReady(name);
    if (!req_ready) return;
    req_valid    = 1'b1;
    req_write    = wr;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    e.name    = name;
    e.due     = cyc + lat;
    e.rdata   = exp_rdata;
    e.err     = exp_err;
    e.reads   = nrd;
    e.writes  = nwr;
    e.rd_base = rd_count;
    e.wr_base = wr_count;
    e.ov_base = ov_count;
    sb.push_back(e);
    stepCycle();
    req_valid = 1'b0;
    req_wdata = 32'h5A5A_5A5A;
    while (sb.size() != 0 && waited < 10) begin
      stepCycle();
      waited++;
    end
    if (sb.size() != 0) begin
      checkOutput({name, "_resp_timeout"}, 32'(sb.size()), 32'h0);
      sb.delete();
    end
  endtask

  // Start a store, assert reset while it is in its write cycle, and confirm it was aborted.
  task automatic resetDuringWrite(input string name, input logic [1:0] sz, input logic [31:0] addr,
                                  input logic [31:0] wdata, input int word_idx, input logic [31:0] exp_word);
    int waited = 0;
    waitReady(name);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_size  = sz;
    req_addr  = addr;
    req_wdata = wdata;
    stepCycle();
    req_valid = 1'b0;
    while (!mem_write && waited < 5) begin
      stepCycle();
      waited++;
    end
    checkOutput({name, "_reached_wr"}, 32'(mem_write), 32'h1);
    reset = 1'b1;
    #1;
    checkOutput({name, "_write_gated"}, 32'(mem_write), 32'h0);
    stepCycle();
    checkOutput({name, "_no_resp_in_reset"}, 32'(resp_valid), 32'h0);
    reset = 1'b0;
    stepCycle();
    checkOutput({name, "_ready_after"}, 32'(req_ready), 32'h1);
    checkOutput({name, "_no_resp_after"}, 32'(resp_valid), 32'h0);
    checkOutput({name, "_word_kept"}, mem[word_idx], exp_word);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset        = 1'b1;
    tb_init      = 1'b1;
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_size     = W;
    req_unsigned = 1'b0;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;
    repeat (3) stepCycle();
    tb_init = 1'b0;

    checkOutput("rst_req_ready", 32'(req_ready), 32'h0);
    checkOutput("rst_resp_valid", 32'(resp_valid), 32'h0);
    checkOutput("rst_resp_rdata", resp_rdata, 32'h0);
    checkOutput("rst_resp_err", 32'(resp_err), 32'h0);
    checkOutput("rst_mem_read", 32'(mem_read), 32'h0);
    checkOutput("rst_mem_write", 32'(mem_write), 32'h0);
    checkOutput("rst_mem_addr", mem_addr, 32'h0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'h0);
    reset = 1'b0;
    stepCycle();
    checkOutput("rst_ready_after", 32'(req_ready), 32'h1);

    // name                 wr    size uns   addr          wdata          exp_rdata      err  lat rd wr
    applyStimulus("ld_w_0",      1'b0, W,  1'b0, 32'h0000_0000, 32'h0,         32'h0000_0005, 1'b0, 2, 1, 0);
    applyStimulus("st_w_10",     1'b1, W,  1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         1'b0, 2, 0, 1);
    applyStimulus("ld_w_10",     1'b0, W,  1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 2, 1, 0);
    applyStimulus("ld_w_top",    1'b0, W,  1'b0, 32'h0000_03FC, 32'h0,         32'hCAFE_F00D, 1'b0, 2, 1, 0);
    applyStimulus("ld_w_oor",    1'b0, W,  1'b0, 32'h0000_0400, 32'h0,         32'h0,         1'b1, 1, 0, 0);
    applyStimulus("ld_w_mis",    1'b0, W,  1'b0, 32'h0000_0012, 32'h0,         32'h0,         1'b1, 1, 0, 0);
    applyStimulus("st_w_mis",    1'b1, W,  1'b0, 32'h0000_0011, 32'h1111_1111, 32'h0,         1'b1, 1, 0, 0);
    applyStimulus("ld_rsvd",     1'b0, RS, 1'b0, 32'h0000_0000, 32'h0,         32'h0,         1'b1, 1, 0, 0);
    applyStimulus("ld_h_13",     1'b0, H,  1'b0, 32'h0000_0013, 32'h0,         32'h0,         1'b1, 1, 0, 0);

`ifdef LSU_SUBWORD_EN
    applyStimulus("st_b_11",     1'b1, B,  1'b0, 32'h0000_0011, 32'h1234_56A5, 32'h0,         1'b0, 3, 1, 1);
    applyStimulus("ld_w_merged", 1'b0, W,  1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_A5EF, 1'b0, 2, 1, 0);
    applyStimulus("ld_bs_11",    1'b0, B,  1'b0, 32'h0000_0011, 32'h0,         32'hFFFF_FFA5, 1'b0, 2, 1, 0);
    applyStimulus("ld_bu_11",    1'b0, B,  1'b1, 32'h0000_0011, 32'h0,         32'h0000_00A5, 1'b0, 2, 1, 0);
    applyStimulus("ld_hs_12",    1'b0, H,  1'b0, 32'h0000_0012, 32'h0,         32'hFFFF_DEAD, 1'b0, 2, 1, 0);
    applyStimulus("st_h_12",     1'b1, H,  1'b0, 32'h0000_0012, 32'hFFFF_BEEF, 32'h0,         1'b0, 3, 1, 1);
    applyStimulus("ld_hu_12",    1'b0, H,  1'b1, 32'h0000_0012, 32'h0,         32'h0000_BEEF, 1'b0, 2, 1, 0);
    applyStimulus("ld_bu_13",    1'b0, B,  1'b1, 32'h0000_0013, 32'h0,         32'h0000_00BE, 1'b0, 2, 1, 0);
    applyStimulus("ld_bs_10",    1'b0, B,  1'b0, 32'h0000_0010, 32'h0,         32'hFFFF_FFEF, 1'b0, 2, 1, 0);
    applyStimulus("ld_hs_10",    1'b0, H,  1'b0, 32'h0000_0010, 32'h0,         32'hFFFF_A5EF, 1'b0, 2, 1, 0);
    applyStimulus("ld_b_oor",    1'b0, B,  1'b1, 32'h0000_0400, 32'h0,         32'h0,         1'b1, 1, 0, 0);
    applyStimulus("st_b_3ff",    1'b1, B,  1'b0, 32'h0000_03FF, 32'h0000_0011, 32'h0,         1'b0, 3, 1, 1);
    applyStimulus("ld_w_3fc",    1'b0, W,  1'b0, 32'h0000_03FC, 32'h0,         32'h11FE_F00D, 1'b0, 2, 1, 0);
    resetDuringWrite("rst_wr_b", B, 32'h0000_0010, 32'h0000_0077, 4, 32'hBEEF_A5EF);
    applyStimulus("ld_w_after",  1'b0, W,  1'b0, 32'h0000_0010, 32'h0,         32'hBEEF_A5EF, 1'b0, 2, 1, 0);
`else
    applyStimulus("ld_b_0",      1'b0, B,  1'b0, 32'h0000_0000, 32'h0,         32'h0,         1'b1, 1, 0, 0);
    applyStimulus("ld_h_12",     1'b0, H,  1'b1, 32'h0000_0012, 32'h0,         32'h0,         1'b1, 1, 0, 0);
    applyStimulus("st_b_11",     1'b1, B,  1'b0, 32'h0000_0011, 32'h0000_00A5, 32'h0,         1'b1, 1, 0, 0);
    applyStimulus("ld_w_kept",   1'b0, W,  1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 2, 1, 0);
    resetDuringWrite("rst_wr_w", W, 32'h0000_0010, 32'h1234_5678, 4, 32'hDEAD_BEEF);
    applyStimulus("ld_w_after",  1'b0, W,  1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 2, 1, 0);
`endif

    repeat (3) stepCycle();
    checkOutput("sb_drained", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
